// File: rtl/ntt_pkg.sv
// ntt_pkg: constants shared by the NTT datapath blocks (butterfly, modred,
// poly_addsub_pipe).
//   OP_ADD / OP_SUB : op encodings for the add/subtract unit
//   LOGQ_DEF, Q_DEF : default coefficient width and modulus (Kyber q)
package ntt_pkg;
  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_SUB   = 1'b1;
  localparam int   LOGQ_DEF = 12;
  localparam int   Q_DEF    = 3329;
endpackage

// File: rtl/addsub_lane.sv
// addsub_lane: one lane of the stage-1 modular add/subtract.
// Produces the raw LOGQ+1-bit sum or difference plus the flag saying the
// second stage must apply a +/-Q correction.
//   a, b : operands, each < Q
//   op   : OP_ADD / OP_SUB
//   t    : a+b, or a-b in (LOGQ+1)-bit two's complement
//   corr : add -> t >= Q ; sub -> borrow (a < b)
module addsub_lane
  import ntt_pkg::*;
#(
  parameter int LOGQ = LOGQ_DEF,
  parameter int Q    = Q_DEF
) (
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] b,
  input  logic            op,
  output logic [LOGQ:0]   t,
  output logic            corr
);
  localparam logic [LOGQ:0] QW = (LOGQ+1)'(Q);

  always_comb begin
    t    = '0;
    corr = 1'b0;
    if (op == OP_SUB) begin
      t    = {1'b0, a} - {1'b0, b};
      corr = (a < b);
    end else begin
      t    = {1'b0, a} + {1'b0, b};
      corr = (t >= QW);
    end
  end
endmodule

// File: rtl/poly_addsub_pipe.sv
// poly_addsub_pipe: L-lane, two-stage pipelined (a +/- b) mod Q over a
// valid/ready stream, framed into polynomials of D coefficients.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input beat handshake
//   op                  : OP_ADD/OP_SUB, taken from beat 0 of each frame
//   a, b                : L packed LOGQ-bit lanes (lane i at [i*LOGQ +: LOGQ])
//   out_valid/out_ready : output beat handshake
//   s, out_last         : result lanes, last-beat-of-frame flag
//   range_err           : sticky "input lane >= Q" flag, only when
//                         POLY_ADDSUB_RANGE_CHK_EN is defined
module poly_addsub_pipe
  import ntt_pkg::*;
#(
  parameter int LOGQ = LOGQ_DEF,
  parameter int Q    = Q_DEF,
  parameter int D    = 256,
  parameter int L    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op,
  input  logic [L*LOGQ-1:0] a,
  input  logic [L*LOGQ-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef POLY_ADDSUB_RANGE_CHK_EN
  output logic            range_err,
`endif
  output logic [L*LOGQ-1:0] s,
  output logic            out_last
);
  localparam int STAGES = 2;
  localparam int NB     = D / L;
  localparam int CW     = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0]   LAST_BEAT = CW'(NB - 1);
  localparam logic [LOGQ:0]   QW        = (LOGQ+1)'(Q);

  logic [L-1:0][LOGQ-1:0] a_l, b_l, s_c;
  logic [L-1:0][LOGQ:0]   t_c, t_q;
  logic [L-1:0]           corr_c, corr_q;
  logic [STAGES:1]        vld_pipe;
  logic [CW-1:0]          cnt;
  logic                   op_lat, op_eff, op_q, last_q;
  logic                   advance, accept;

  assign a_l = a;
  assign b_l = b;

  // Both stages move as one; an empty output slot lets a bubble be filled
  // even while downstream is stalled.
  assign advance   = out_ready || !out_valid;
  assign in_ready  = rst_n && advance;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_pipe[STAGES];

  // Beat 0 uses the live op; later beats use the value latched on beat 0.
  assign op_eff = (cnt == '0) ? op : op_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_lat <= OP_ADD;
    end else if (accept) begin
      if (cnt == '0) op_lat <= op;
      cnt <= (cnt == LAST_BEAT) ? '0 : cnt + CW'(1);
    end
  end

  for (genvar g = 0; g < L; g++) begin : g_lane
    logic [LOGQ:0] fix;

    addsub_lane #(.LOGQ(LOGQ), .Q(Q)) u_lane (
      .a    (a_l[g]),
      .b    (b_l[g]),
      .op   (op_eff),
      .t    (t_c[g]),
      .corr (corr_c[g])
    );

    // Stage-2 correction; for subtract, t+Q wraps mod 2^(LOGQ+1) so the
    // low LOGQ bits are the right residue.
    assign fix      = !corr_q[g] ? t_q[g] :
                      (op_q == OP_SUB) ? t_q[g] + QW : t_q[g] - QW;
    assign s_c[g]   = fix[LOGQ-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      t_q      <= '0;
      corr_q   <= '0;
      op_q     <= OP_ADD;
      last_q   <= 1'b0;
      s        <= '0;
      out_last <= 1'b0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      t_q      <= t_c;
      corr_q   <= corr_c;
      op_q     <= op_eff;
      last_q   <= accept && (cnt == LAST_BEAT);
      s        <= s_c;
      out_last <= last_q;
    end
  end

`ifdef POLY_ADDSUB_RANGE_CHK_EN
  localparam logic [LOGQ-1:0] QN = LOGQ'(Q);
  logic [L-1:0] oor;

  for (genvar g = 0; g < L; g++) begin : g_rchk
    assign oor[g] = (a_l[g] >= QN) || (b_l[g] >= QN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 range_err <= 1'b0;
    else if (accept && |oor)    range_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_poly_addsub_pipe.sv
// tb_poly_addsub_pipe: table-driven vectors plus hand sequences for
// backpressure, mid-frame reset and (optionally) range checking; results
// are checked through a scoreboard queue filled at input acceptance.
module tb_poly_addsub_pipe;
  localparam int LOGQ = 12;
  localparam int Q    = 3329;
  localparam int D    = 8;
  localparam int L    = 4;
  localparam int NB   = D / L;

  typedef logic [L*LOGQ-1:0] vec_t;
  typedef struct packed { logic op; vec_t a; vec_t b; vec_t s; logic last; } vec_rec_t;
  typedef struct packed { vec_t s; logic last; logic chk; } sb_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, op_i = 1'b0, out_ready = 1'b1;
  vec_t a_i = '0, b_i = '0;
  logic in_ready, out_valid, out_last;
  vec_t s;
`ifdef POLY_ADDSUB_RANGE_CHK_EN
  logic range_err;
`endif

  poly_addsub_pipe #(.LOGQ(LOGQ), .Q(Q), .D(D), .L(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op_i), .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
`ifdef POLY_ADDSUB_RANGE_CHK_EN
    .range_err(range_err),
`endif
    .s(s), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  sb_t exp_q[$];
  int   m_cnt = 0;
  logic m_op  = 1'b0;
  logic hold_pend = 1'b0;
  vec_t held_s;
  logic held_last;

  function automatic vec_t pk(input int x0, input int x1, input int x2, input int x3);
    vec_t v;
    v[0*LOGQ +: LOGQ] = LOGQ'(x0);
    v[1*LOGQ +: LOGQ] = LOGQ'(x1);
    v[2*LOGQ +: LOGQ] = LOGQ'(x2);
    v[3*LOGQ +: LOGQ] = LOGQ'(x3);
    return v;
  endfunction

  function automatic vec_t model(input logic o, input vec_t x, input vec_t y);
    vec_t r;
    for (int i = 0; i < L; i++) begin
      int p, q, t;
      p = int'(x[i*LOGQ +: LOGQ]);
      q = int'(y[i*LOGQ +: LOGQ]);
      t = o ? (p - q + Q) % Q : (p + q) % Q;
      r[i*LOGQ +: LOGQ] = LOGQ'(t);
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Record the expected output for a beat the DUT is about to accept.
  task automatic push_beat(input logic o, input vec_t x, input vec_t y,
                           input bit use_tbl, input vec_t ts, input logic tl, input bit chk);
    sb_t e;
    if (m_cnt == 0) m_op = o;
    e.s    = use_tbl ? ts : model(m_op, x, y);
    e.last = use_tbl ? tl : (m_cnt == NB - 1);
    e.chk  = chk;
    exp_q.push_back(e);
    m_cnt = (m_cnt == NB - 1) ? 0 : m_cnt + 1;
  endtask

  task automatic drive(input logic o, input vec_t x, input vec_t y);
    @(posedge clk); #1;
    in_valid = 1'b1; op_i = o; a_i = x; b_i = y;
  endtask

  task automatic wait_acc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; return; end
    end
    mismatched++;
    $display("FAIL accept_timeout: in_ready stayed 0 for 100 cycles, want 1");
  endtask

  task automatic send(input logic o, input vec_t x, input vec_t y,
                      input bit use_tbl, input vec_t ts, input logic tl, input bit chk);
    bit ok;
    drive(o, x, y);
    wait_acc(ok);
    if (ok) push_beat(o, x, y, use_tbl, ts, tl, chk);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) return;
    end
    mismatched++;
    $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
  endtask

  // Output side: compare on every handshake, and check that a stalled
  // output holds its value.
  always @(negedge clk) begin
    if (rst_n && hold_pend) begin
      check("hold_s", 64'(s), 64'(held_s));
      check("hold_last", 64'(out_last), 64'(held_last));
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_out: s=%0h with empty scoreboard, want no output", s);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        if (e.chk) check("s", 64'(s), 64'(e.s));
        check("out_last", 64'(out_last), 64'(e.last));
      end
    end
    hold_pend = rst_n && out_valid && !out_ready;
    held_s    = s;
    held_last = out_last;
  end

  vec_rec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // add: 3328+1, 1000+2329, 0+0, 1664+1665 all reduce to 0
    tbl[0] = '{1'b0, pk(3328,1000,0,1664), pk(1,2329,0,1665), pk(0,0,0,0), 1'b0};
    tbl[1] = '{1'b0, pk(5,5,5,5),          pk(7,7,7,7),       pk(12,12,12,12), 1'b1};
    // subtract with borrows
    tbl[2] = '{1'b1, pk(0,5,3328,100),     pk(1,5,0,3328),    pk(3328,0,3328,101), 1'b0};
    tbl[3] = '{1'b0, pk(10,3328,0,7),      pk(20,3328,1,0),   pk(3319,0,3328,7), 1'b1};
    // op switch on beat 1 ignored: still add
    tbl[4] = '{1'b0, pk(1,0,3000,2),       pk(2,0,328,3),     pk(3,0,3328,5), 1'b0};
    tbl[5] = '{1'b1, pk(3328,1,2000,0),    pk(3328,3328,2000,0), pk(3327,0,671,0), 1'b1};
    // next frame's beat 0 carries op=1, beat 1 op=0 ignored
    tbl[6] = '{1'b1, pk(2,3328,0,9),       pk(3,3328,3328,4), pk(3328,0,1,5), 1'b0};
    tbl[7] = '{1'b0, pk(7,100,1,3328),     pk(3,200,3328,1),  pk(4,3229,2,3327), 1'b1};
    // back-to-back frame, add at the top edge
    tbl[8] = '{1'b0, pk(3328,3328,1664,1665), pk(3328,0,1664,1664), pk(3327,3328,3328,0), 1'b0};
    tbl[9] = '{1'b1, pk(9,9,9,9),          pk(1,2,3,4),       pk(10,11,12,13), 1'b1};

    #23 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_s", 64'(s), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);

    for (int i = 0; i < 10; i++)
      send(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, tbl[i].s, tbl[i].last, 1'b1);
    idle();
    drain();

    // Backpressure: two beats fill the pipe, third waits while stalled.
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      send(1'b0, pk($urandom_range(0,Q-1), 11, 22, 33), pk($urandom_range(0,Q-1), 44, 55, 66),
           1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, pk(100, 200, 300, 400), pk(400, 300, 200, 100));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    begin
      bit ok;
      wait_acc(ok);
      if (ok) push_beat(1'b1, pk(100, 200, 300, 400), pk(400, 300, 200, 100), 1'b0, '0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++)
      send(i[0], pk($urandom_range(0,Q-1), $urandom_range(0,Q-1), $urandom_range(0,Q-1), 3328),
           pk($urandom_range(0,Q-1), $urandom_range(0,Q-1), $urandom_range(0,Q-1), 3328),
           1'b0, '0, 1'b0, 1'b1);
    idle();
    drain();

    // Mid-frame reset: beat 0 accepted, then reset discards it.
    send(1'b0, pk(1,1,1,1), pk(1,1,1,1), 1'b0, '0, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(1'b1, pk(5,5,5,5), pk(3,3,3,3), 1'b1, pk(2,2,2,2), 1'b0, 1'b1);
    send(1'b0, pk(5,0,0,0), pk(6,0,0,0), 1'b1, pk(3328,0,0,0), 1'b1, 1'b1);
    idle();
    drain();

`ifdef POLY_ADDSUB_RANGE_CHK_EN
    check("rerr_clear", 64'(range_err), 64'd0);
    send(1'b0, pk(3329,1,1,1), pk(0,1,1,1), 1'b0, '0, 1'b0, 1'b0);
    idle();
    check("rerr_set", 64'(range_err), 64'd1);
    send(1'b0, pk(1,1,1,1), pk(2,2,2,2), 1'b0, '0, 1'b0, 1'b1);
    idle();
    drain();
    check("rerr_sticky", 64'(range_err), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
